// File: rtl/dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem : RV32IM data memory with fixed multi-cycle latency, byte-lane       |
// |        stores and sign/zero-extended loads; busywait stalls the pipeline.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic [31:0] DEBUG_DATA,
  output logic        DEBUG_READ_ACC,
  output logic        DEBUG_WRITE_ACC
);

  localparam int c_AW = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
  localparam int c_CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   w_count_nxt;

  logic              r_store;
  logic [2:0]        r_rtype;
  logic [1:0]        r_wsize;
  logic [c_AW+1:0]   r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_pending;
  logic              w_latch;
  logic              w_do_access;
  logic              w_use_live;

  logic              w_acc_store;
  logic [2:0]        w_acc_rtype;
  logic [1:0]        w_acc_wsize;
  logic [c_AW+1:0]   w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [c_AW-1:0]   w_idx;
  logic [31:0]       w_word;
  logic [31:0]       w_wmask;
  logic [31:0]       w_wword;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [31:0]       w_load;
  logic              w_unused_addr;

  assign w_pending     = write[2] | read[3];
  assign w_unused_addr = ^address[31:c_AW+2];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    busywait    = 1'b0;
    w_latch     = 1'b0;
    w_do_access = 1'b0;
    w_use_live  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busywait = w_pending;
        if (w_pending) begin
          w_latch     = 1'b1;
          w_count_nxt = c_CW'(1);
          if (LATENCY == 1) begin
            // Single-cycle access: the latches are not loaded yet, use the live request.
            w_do_access = 1'b1;
            w_use_live  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        busywait    = 1'b1;
        w_count_nxt = r_count + c_CW'(1);
        if (r_count == c_LAST) begin
          w_do_access = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_acc_store = w_use_live ? write[2]              : r_store;
  assign w_acc_rtype = w_use_live ? read[2:0]             : r_rtype;
  assign w_acc_wsize = w_use_live ? write[1:0]            : r_wsize;
  assign w_acc_addr  = w_use_live ? address[c_AW+1:0]     : r_addr;
  assign w_acc_wdata = w_use_live ? writedata             : r_wdata;
  assign w_idx       = w_acc_addr[c_AW+1:2];
  assign w_word      = r_mem[w_idx];

  // Sub-word stores replicate the data across lanes; the mask picks the lane.
  always_comb begin
    w_wmask = 32'hFFFF_FFFF;
    w_wword = w_acc_wdata;
    case (w_acc_wsize)
      2'b01: begin
        w_wmask = w_acc_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wword = {2{w_acc_wdata[15:0]}};
      end
      2'b10: begin
        w_wmask = 32'h0000_00FF << {w_acc_addr[1:0], 3'b000};
        w_wword = {4{w_acc_wdata[7:0]}};
      end
      default: begin
        w_wmask = 32'hFFFF_FFFF;
        w_wword = w_acc_wdata;
      end
    endcase
  end

  assign w_half = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (w_acc_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_load = w_word;
    case (w_acc_rtype)
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      3'b110:  w_load = {24'h000000, w_byte};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_store         <= 1'b0;
      r_rtype         <= '0;
      r_wsize         <= '0;
      r_addr          <= '0;
      r_wdata         <= '0;
      readdata        <= '0;
      DEBUG_DATA      <= '0;
      DEBUG_READ_ACC  <= 1'b0;
      DEBUG_WRITE_ACC <= 1'b0;
    end else begin
      if (w_latch) begin
        r_store <= write[2];
        r_rtype <= read[2:0];
        r_wsize <= write[1:0];
        r_addr  <= address[c_AW+1:0];
        r_wdata <= writedata;
      end
      DEBUG_READ_ACC  <= w_do_access & ~w_acc_store;
      DEBUG_WRITE_ACC <= w_do_access & w_acc_store;
      if (w_do_access) begin
        if (w_acc_store) begin
          DEBUG_DATA <= w_acc_wdata;
        end else begin
          readdata   <= w_load;
          DEBUG_DATA <= w_load;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_access && w_acc_store) begin
      r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wword & w_wmask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem : directed self-checking bench for dmem (256 words, latency 4).    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dmem;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  read;
  logic [2:0]  write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;
  logic [31:0] DEBUG_DATA;
  logic        DEBUG_READ_ACC;
  logic        DEBUG_WRITE_ACC;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd = 32'h0;

  dmem #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .write          (write),
    .address        (address),
    .writedata      (writedata),
    .readdata       (readdata),
    .busywait       (busywait),
    .DEBUG_DATA     (DEBUG_DATA),
    .DEBUG_READ_ACC (DEBUG_READ_ACC),
    .DEBUG_WRITE_ACC(DEBUG_WRITE_ACC)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; exp_load is the expected load result (ignored for stores).
  task automatic access(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_load);
    int   n;
    logic st;
    st = wr[2];
    @(negedge clock);
    read = rd; write = wr; address = a; writedata = wd;
    #1;
    n = 0;
    while (busywait && n < 20) begin
      n++;
      @(negedge clock);
      #1;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(LAT));
    chk({tag, " wr_strobe"}, {31'b0, DEBUG_WRITE_ACC}, {31'b0, st});
    chk({tag, " rd_strobe"}, {31'b0, DEBUG_READ_ACC}, {31'b0, ~st});
    if (st) begin
      chk({tag, " debug_data"}, DEBUG_DATA, wd);
      chk({tag, " readdata_hold"}, readdata, last_rd);
    end else begin
      last_rd = exp_load;
      chk({tag, " debug_data"}, DEBUG_DATA, exp_load);
      chk({tag, " readdata"}, readdata, exp_load);
    end
    read = 4'b0; write = 3'b0;
    @(negedge clock);
    #1;
    chk({tag, " idle_after"}, {29'b0, busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; read = 4'b0; write = 3'b0; address = 32'h0; writedata = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("reset readdata", readdata, 32'h0);
    chk("reset debug_data", DEBUG_DATA, 32'h0);
    chk("reset busy/strobes", {29'b0, busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC}, 32'h0);

    access("SW 04", 4'b0000, 3'b100, 32'h04, 32'hAABBCCDD, 32'h0);
    access("LW 04", 4'b1000, 3'b000, 32'h04, 32'h0, 32'hAABBCCDD);
    access("SW 08", 4'b0000, 3'b100, 32'h08, 32'h11223344, 32'h0);
    access("LW 08", 4'b1000, 3'b000, 32'h08, 32'h0, 32'h11223344);
    access("LW 04 again", 4'b1000, 3'b000, 32'h04, 32'h0, 32'hAABBCCDD);

    access("LB 05",  4'b1010, 3'b000, 32'h05, 32'h0, 32'hFFFFFFCC);
    access("LBU 07", 4'b1110, 3'b000, 32'h07, 32'h0, 32'h000000AA);
    access("LH 06",  4'b1001, 3'b000, 32'h06, 32'h0, 32'hFFFFAABB);
    access("LHU 04", 4'b1101, 3'b000, 32'h04, 32'h0, 32'h0000CCDD);

    access("SB 09", 4'b0000, 3'b110, 32'h09, 32'hFFFFFF5A, 32'h0);
    access("LW 08 after SB", 4'b1000, 3'b000, 32'h08, 32'h0, 32'h11225A44);
    access("SH 0A", 4'b0000, 3'b101, 32'h0A, 32'h1234BEEF, 32'h0);
    access("LW 08 after SH", 4'b1000, 3'b000, 32'h08, 32'h0, 32'hBEEF5A44);

    // Abort a store partway through with reset.
    @(negedge clock);
    read = 4'b0; write = 3'b100; address = 32'h0C; writedata = 32'hDEADBEEF;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; write = 3'b000;
    @(negedge clock);
    #1;
    chk("abort busy/strobes", {29'b0, busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC}, 32'h0);
    chk("abort debug_data", DEBUG_DATA, 32'h0);
    reset = 1'b0;
    last_rd = 32'h0;
    @(negedge clock);
    #1;
    chk("post-abort busy/strobes", {29'b0, busywait, DEBUG_READ_ACC, DEBUG_WRITE_ACC}, 32'h0);
    chk("post-abort readdata", readdata, 32'h0);
    access("LW 0C after abort", 4'b1000, 3'b000, 32'h0C, 32'h0, 32'h0);

    access("RW both 10", 4'b1000, 3'b100, 32'h10, 32'h12345678, 32'h0);
    access("LW 10", 4'b1000, 3'b000, 32'h10, 32'h0, 32'h12345678);
    access("LW 13 misaligned", 4'b1000, 3'b000, 32'h13, 32'h0, 32'h12345678);

    access("SW 400 alias", 4'b0000, 3'b100, 32'h400, 32'hCAFEF00D, 32'h0);
    access("LW 000 alias", 4'b1000, 3'b000, 32'h000, 32'h0, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem.md
# dmem

Data memory for the RV32IM pipeline's memory-access (MA) stage. It services one load or store at a time with a fixed multi-cycle latency and stalls the pipeline through `busywait` until the access completes. Loads return byte, halfword or word data with sign or zero extension. Debug outputs expose the last completed access for the bench and the top level.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two.
- `LATENCY`, default 4: cycles `busywait` stays high per access; must be ≥1.

Ports:
- `clock`  in  1  single clock; everything is updated on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read`  in  4  bit 3 is load enable. Bits 2:0 select the load type: 000 word, 001 half signed, 010 byte signed, 101 half unsigned, 110 byte unsigned. Other codes read as a word.
- `write`  in  3  bit 2 is store enable. Bits 1:0 select the store size: 00 word, 01 half, 10 byte, 11 word.
- `address`  in  32  byte address.
- `writedata`  in  32  store data; halfword uses bits 15:0, byte uses bits 7:0.
- `readdata`  out  32  extended load result.
- `busywait`  out  1  stall request to the pipeline.
- `DEBUG_DATA`  out  32  data of the last completed access: the load result, or the full `writedata` word for a store.
- `DEBUG_READ_ACC`  out  1  one-cycle strobe when a load completes.
- `DEBUG_WRITE_ACC`  out  1  one-cycle strobe when a store completes.

## Operation
- The word index is `address[log2(DEPTH_WORDS)+1:2]`; higher address bits are ignored, so addresses wrap.
- Misaligned accesses are aligned down:
  - word: `address[1:0]` ignored;
  - half: `address[1]` selects the lane, `address[0]` ignored;
  - byte: `address[1:0]` selects the lane.
- Stores use a byte-lane write and leave the other bytes of the word unchanged.
- Loads extract the addressed lane and sign- or zero-extend it to 32 bits.
- A request is pending when `write[2]` or `read[3]` is high. If both are high, the store takes priority and the load is ignored.
- The requester holds `read`, `write`, `address` and `writedata` stable while `busywait` is high.
- The request is sampled on the first busy cycle. Changes to the inputs after that cycle do not affect the access in progress.
- State machine:
  - IDLE: `busywait` = pending request (combinational). If a request is pending, latch it, set count to 1, and go to BUSY; if `LATENCY`=1, perform the access at this edge and go to DONE.
  - BUSY: `busywait`=1. Increment the count. When count = `LATENCY`-1, perform the access at this edge and go to DONE.
  - DONE: `busywait`=0. Pulse the matching debug strobe and go to IDLE. A request present during DONE is not serviced until the next IDLE cycle.
- `readdata` changes only when a load completes and then holds its value.
- `DEBUG_DATA` changes only when an access completes.
- Reset values:
  - state IDLE, count 0;
  - `readdata`, `DEBUG_DATA` = 0;
  - both strobes 0;
  - all memory words cleared to 0.
  - `busywait` follows the combinational IDLE rule.
- Reset during BUSY aborts the access: no array write, no `readdata` update, no strobe.

## Timing
- A request first seen in cycle 0 keeps `busywait` high in cycles 0 through `LATENCY`-1.
- The array write or `readdata` capture happens at the rising edge that ends cycle `LATENCY`-1.
- In cycle `LATENCY`:
  - `busywait`=0;
  - `readdata` is valid;
  - the debug strobe is high for exactly this one cycle.
- A new access can start earliest in cycle `LATENCY`+1. Back-to-back accesses therefore take `LATENCY`+1 cycles each.
- There is no combinational path from `address` or `writedata` to `readdata`.

## Test plan
- Reset, then store 0xAABBCCDD to 0x04 with `write`=100 held until `busywait` falls. Check `busywait` is high for 4 cycles, then `DEBUG_WRITE_ACC`=1 and `DEBUG_DATA`=0xAABBCCDD. Then load 0x04 with `read`=1000 and check `readdata`=0xAABBCCDD and `DEBUG_READ_ACC` pulses.
- Store 0x11223344 to 0x08 and load 0x08: `readdata`=0x11223344. Reload 0x04: still 0xAABBCCDD.
- With 0xAABBCCDD at 0x04:
  - LB at 0x05 → 0xFFFFFFCC;
  - LBU at 0x07 → 0x000000AA;
  - LH at 0x06 → 0xFFFFAABB;
  - LHU at 0x04 → 0x0000CCDD.
- Store byte 0x5A (SB) to 0x09 over 0x11223344, then load the word at 0x08 → 0x11225A44. Store half 0xBEEF (SH) to 0x0A → word reads 0xBEEF5A44.
- Assert `reset` in BUSY during a store of 0xDEADBEEF to 0x0C. Check no strobe fires, `busywait` drops after reset, and a later load of 0x0C returns 0.
- Raise `read` and `write` together (store 0x12345678 to 0x10). Check only `DEBUG_WRITE_ACC` pulses and a later load of 0x10 returns 0x12345678. Check an address of 0x400 aliases to 0x000 (`DEPTH_WORDS`=256).
